// File: rtl/u_dly_pkg.sv
// u_dly_pkg: shared encodings and thermometer decode for delay-chain controllers
package u_dly_pkg;
    localparam int MAX_CELLS = 64;
    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_UPDATE, S_LOCK} state_t;
    typedef enum logic [1:0] {D_HOLD, D_UP, D_DN} dir_t;
    function automatic logic [MAX_CELLS-1:0] therm(input logic [6:0] code);
        for (int k = 0; k < MAX_CELLS; k++) therm[k] = (k < int'(code));
    endfunction
endpackage

// File: rtl/u_dly_vote_filt.sv
// u_dly_vote_filt: counts early/late phase-detector votes over one window and
// reports the filtered step direction from the accumulated counts.
module u_dly_vote_filt
    import u_dly_pkg::*;
#(
    parameter int FILT_LEN = 16,
    parameter int FILT_TH  = 12,
    localparam int VW = $clog2(FILT_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic          early,
    input  logic          late,
    output logic [VW-1:0] early_cnt,
    output logic [VW-1:0] late_cnt,
    output dir_t          dir
);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            early_cnt <= '0;
            late_cnt  <= '0;
        end else if (enable) begin
            early_cnt <= early_cnt + VW'(early & ~late);
            late_cnt  <= late_cnt + VW'(late & ~early);
        end
    end
    assign dir = early_cnt >= VW'(FILT_TH) ? D_UP : late_cnt >= VW'(FILT_TH) ? D_DN : D_HOLD;
endmodule

// File: rtl/u_dly_cal_ctrl.sv
// u_dly_cal_ctrl: closed-loop delay-chain calibration (settle, vote, step, lock).
// Define DLY_CAL_TRACK_EN to keep tracking after lock instead of freezing.
module u_dly_cal_ctrl
    import u_dly_pkg::*;
#(
    parameter int N_CELL     = 16,
    parameter int SETTLE_CYC = 8,
    parameter int FILT_LEN   = 16,
    parameter int FILT_TH    = 12,
    parameter int LOCK_FLIPS = 4,
    localparam int CW = $clog2(N_CELL + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cal_start,
    input  logic              i_early,
    input  logic              i_late,
    output logic [N_CELL-1:0] o_sel,
    output logic [CW-1:0]     o_code,
    output logic              o_busy,
    output logic              o_locked,
    output logic              o_sat_err
);
    localparam int TW = $clog2((SETTLE_CYC > FILT_LEN ? SETTLE_CYC : FILT_LEN) + 1);
    localparam int FW = $clog2(LOCK_FLIPS + 1);
    localparam int VW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] MID = CW'(N_CELL / 2);
`ifdef DLY_CAL_TRACK_EN
    localparam state_t LOCK_TO = S_SETTLE;
`else
    localparam state_t LOCK_TO = S_LOCK;
`endif

    state_t          state, state_nxt;
    dir_t            dir, last_dir, last_nxt;
    logic [TW-1:0]   tmr, tmr_nxt;
    logic [CW-1:0]   code_nxt;
    logic [FW-1:0]   flips, flips_nxt;
    logic            locked_nxt, sat_nxt, start, lim, rev;
    logic [VW-1:0]   early_cnt, late_cnt;

    u_dly_vote_filt #(.FILT_LEN(FILT_LEN), .FILT_TH(FILT_TH)) u_filt (
        .clk       (i_clk),
        .rst       (i_rst),
        .clear     (state == S_SETTLE),
        .enable    (state == S_SAMPLE),
        .early     (i_early),
        .late      (i_late),
        .early_cnt (early_cnt),
        .late_cnt  (late_cnt),
        .dir       (dir)
    );

    assign o_busy = (state == S_SETTLE || state == S_SAMPLE || state == S_UPDATE) && !o_locked;
    assign o_sel  = N_CELL'(therm(7'(o_code)));
    assign start  = i_cal_start && !o_busy;
    assign lim    = (dir == D_UP && o_code == CW'(N_CELL)) || (dir == D_DN && o_code == '0);
    // Reversal counting only matters while acquiring; a tracking loop ignores it.
    assign rev    = !o_locked && last_dir != D_HOLD && dir != last_dir;

    always_comb begin
        state_nxt  = state;
        tmr_nxt    = tmr;
        code_nxt   = o_code;
        flips_nxt  = flips;
        last_nxt   = last_dir;
        locked_nxt = o_locked;
        sat_nxt    = o_sat_err;
        if (start) begin
            state_nxt  = S_SETTLE;
            tmr_nxt    = '0;
            code_nxt   = MID;
            flips_nxt  = '0;
            last_nxt   = D_HOLD;
            locked_nxt = 1'b0;
            sat_nxt    = 1'b0;
        end else begin
            case (state)
                S_SETTLE: begin
                    tmr_nxt = tmr + 1'b1;
                    if (tmr == TW'(SETTLE_CYC - 1)) begin
                        state_nxt = S_SAMPLE;
                        tmr_nxt   = '0;
                    end
                end
                S_SAMPLE: begin
                    tmr_nxt = tmr + 1'b1;
                    if (tmr == TW'(FILT_LEN - 1)) begin
                        state_nxt = S_UPDATE;
                        tmr_nxt   = '0;
                    end
                end
                S_UPDATE: begin
                    state_nxt = S_SETTLE;
                    if (dir == D_HOLD) begin
                        locked_nxt = 1'b1;
                        state_nxt  = LOCK_TO;
                    end else if (lim) begin
                        sat_nxt    = 1'b1;
                        locked_nxt = 1'b0;
                        state_nxt  = S_IDLE;
                    end else begin
                        code_nxt = dir == D_UP ? o_code + 1'b1 : o_code - 1'b1;
                        last_nxt = dir;
                        if (rev) flips_nxt = flips + 1'b1;
                        if (rev && flips == FW'(LOCK_FLIPS - 1)) begin
                            locked_nxt = 1'b1;
                            state_nxt  = LOCK_TO;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            tmr       <= '0;
            o_code    <= MID;
            flips     <= '0;
            last_dir  <= D_HOLD;
            o_locked  <= 1'b0;
            o_sat_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            o_code    <= code_nxt;
            flips     <= flips_nxt;
            last_dir  <= last_nxt;
            o_locked  <= locked_nxt;
            o_sat_err <= sat_nxt;
        end
    end
endmodule

// File: tb/tb_u_dly_cal_ctrl.sv
// tb_u_dly_cal_ctrl: directed table-driven bench for u_dly_cal_ctrl at default parameters.
// Expectations switch with DLY_CAL_TRACK_EN where tracking changes post-lock behaviour.
module tb_u_dly_cal_ctrl;
    logic        i_clk = 1'b0;
    logic        i_rst, i_cal_start, i_early, i_late;
    logic [15:0] o_sel;
    logic [4:0]  o_code;
    logic        o_busy, o_locked, o_sat_err;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 i_clk = ~i_clk;

    u_dly_cal_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cal_start (i_cal_start),
        .i_early     (i_early),
        .i_late      (i_late),
        .o_sel       (o_sel),
        .o_code      (o_code),
        .o_busy      (o_busy),
        .o_locked    (o_locked),
        .o_sat_err   (o_sat_err)
    );

    // mode: 0 early, 1 alternate per window, 2 even/odd split, 3 late, 4 split first window then late
    typedef struct {
        string      name;
        int         mode;
        int         edges;
        logic [4:0] code;
        logic       busy;
        logic       locked;
        logic       sat;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [4:0] code, input logic busy,
                           input logic locked, input logic sat);
        logic [16:0] t;
        t = (17'd1 << code) - 17'd1;
        chk({name, ".code"}, 32'(o_code), 32'(code));
        chk({name, ".sel"}, 32'(o_sel), 32'(t[15:0]));
        chk({name, ".busy"}, 32'(o_busy), 32'(busy));
        chk({name, ".locked"}, 32'(o_locked), 32'(locked));
        chk({name, ".sat"}, 32'(o_sat_err), 32'(sat));
    endtask

    task automatic drive(input int mode, input int e);
        int w, p;
        logic ea;
        w = (e - 1) / 25;
        p = (e - 1) % 25;
        case (mode)
            0: ea = 1'b1;
            1: ea = (w % 2 == 0);
            2: ea = (p % 2 == 0);
            3: ea = 1'b0;
            default: ea = (w == 0) ? (p % 2 == 0) : 1'b0;
        endcase
        i_early = ea;
        i_late  = ~ea;
    endtask

    task automatic run(input int mode, input int n, input int pulse_at, input bit do_rst);
        if (do_rst) begin
            @(negedge i_clk);
            i_rst = 1'b1;
            @(posedge i_clk);
            @(negedge i_clk);
            i_rst = 1'b0;
        end
        @(negedge i_clk);
        i_cal_start = 1'b1;
        @(posedge i_clk);
        for (int e = 1; e <= n; e++) begin
            @(negedge i_clk);
            i_cal_start = (e == pulse_at);
            drive(mode, e);
            @(posedge i_clk);
        end
        #1;
    endtask

    initial begin
        i_rst = 1'b1;
        i_cal_start = 1'b0;
        i_early = 1'b0;
        i_late = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk_all("reset", 5'd8, 1'b0, 1'b0, 1'b0);
        chk("reset.sel_lit", 32'(o_sel), 32'h00FF);
        @(negedge i_clk);
        i_rst = 1'b0;

        vecs.push_back('{"up_e24", 0, 24, 5'd8, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"up_e25", 0, 25, 5'd9, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"up_e50", 0, 50, 5'd10, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"up_e200", 0, 200, 5'd16, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"up_sat", 0, 225, 5'd16, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"dn_e25", 3, 25, 5'd7, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"dn_sat", 3, 225, 5'd0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"hold", 2, 25, 5'd8, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"hold_e60", 2, 60, 5'd8, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"alt_e100", 1, 100, 5'd8, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"alt_lock", 1, 125, 5'd9, 1'b0, 1'b1, 1'b0});
`ifdef DLY_CAL_TRACK_EN
        vecs.push_back('{"alt_trk", 1, 150, 5'd8, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"trk_dn", 4, 50, 5'd7, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"trk_e75", 4, 75, 5'd6, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"trk_sat", 4, 250, 5'd0, 1'b0, 1'b0, 1'b1});
`else
        vecs.push_back('{"alt_frz", 1, 150, 5'd9, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"hold_frz", 4, 50, 5'd8, 1'b0, 1'b1, 1'b0});
`endif
        foreach (vecs[i]) begin
            run(vecs[i].mode, vecs[i].edges, -1, 1'b1);
            chk_all(vecs[i].name, vecs[i].code, vecs[i].busy, vecs[i].locked, vecs[i].sat);
        end

        // Reset in the middle of the second sample window
        run(0, 35, -1, 1'b1);
        chk("mid.code_pre", 32'(o_code), 32'd9);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        chk_all("mid_rst", 5'd8, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Start pulse while busy must not restart the window timing
        run(0, 24, 15, 1'b1);
        chk("busy_start.e24", 32'(o_code), 32'd8);
        @(negedge i_clk);
        i_cal_start = 1'b0;
        @(posedge i_clk);
        #1;
        chk("busy_start.e25", 32'(o_code), 32'd9);

        // Restart after saturation clears the sticky error
        run(0, 225, -1, 1'b1);
        chk("resat.sat", 32'(o_sat_err), 32'd1);
        run(0, 1, -1, 1'b0);
        chk_all("restart", 5'd8, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
